// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared constants and state encoding for the RC4 keystream/decrypt engine

package rc4_pkg;

    localparam int S_DEPTH = 256;
    localparam int S_AW    = $clog2(S_DEPTH);

    // Accepted plaintext alphabet: lowercase letters and space
    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        RD_I,
        WT_I,
        CP_I,
        RD_J,
        WT_J,
        CP_J,
        WR_I,
        WR_J,
        RD_F,
        WT_F,
        WR_O,
        DONE
    } state_t;

endpackage

// File: rtl/rc4_char_check.sv
// rtl/rc4_char_check.sv - combinational test that a byte is a lowercase letter or space

module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] data,
    output logic       ok
);

    assign ok = ((data >= CHAR_LO) && (data <= CHAR_HI)) || (data == CHAR_SP);

endmodule

// File: rtl/rc4_prga_fsm.sv
// rtl/rc4_prga_fsm.sv - RC4 keystream generator that decrypts a ciphertext ROM into plaintext RAM

module rc4_prga_fsm
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              check_en,
    output logic              finish,
    output logic              busy,
    output logic              valid,
    output logic [S_AW-1:0]   s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [MSG_AW-1:0] rom_address,
    input  logic [7:0]        rom_q,
    output logic [MSG_AW-1:0] d_address,
    output logic [7:0]        d_data,
    output logic              d_wren
);

    state_t            state;
    state_t            state_nx;

    logic [S_AW-1:0]   i_r;
    logic [S_AW-1:0]   j_r;
    logic [7:0]        si_r;
    logic [7:0]        sj_r;
    logic [MSG_AW-1:0] k_r;
    logic              chk_r;
    logic              valid_r;

    logic [7:0]        plain;
    logic              char_ok;
    logic              chk_fail;
    logic              last_byte;

    // Keystream byte and ciphertext both arrive in WR_O; plaintext is their XOR
    assign plain     = s_q ^ rom_q;
    assign chk_fail  = chk_r & ~char_ok;
    assign last_byte = (k_r == MSG_AW'(MSG_LEN - 1));
    assign valid     = valid_r;

    rc4_char_check u_char_check (
        .data (plain),
        .ok   (char_ok)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: fixed 11-state walk per byte, early exit on a failed character check
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = INIT;
            INIT:    state_nx = RD_I;
            RD_I:    state_nx = WT_I;
            WT_I:    state_nx = CP_I;
            CP_I:    state_nx = RD_J;
            RD_J:    state_nx = WT_J;
            WT_J:    state_nx = CP_J;
            CP_J:    state_nx = WR_I;
            WR_I:    state_nx = WR_J;
            WR_J:    state_nx = RD_F;
            RD_F:    state_nx = WT_F;
            WT_F:    state_nx = WR_O;
            WR_O:    state_nx = (chk_fail || last_byte) ? DONE : RD_I;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath registers: indices, the two swapped S bytes, run flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i_r     <= '0;
            j_r     <= '0;
            k_r     <= '0;
            si_r    <= '0;
            sj_r    <= '0;
            chk_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i_r     <= '0;
                        j_r     <= '0;
                        k_r     <= '0;
                        chk_r   <= check_en;
                        valid_r <= 1'b0;
                    end
                end
                RD_I: i_r  <= i_r + 8'd1;
                CP_I: begin
                    si_r <= s_q;
                    j_r  <= j_r + s_q;
                end
                CP_J: sj_r <= s_q;
                WR_O: begin
                    if (chk_fail) begin
                        valid_r <= 1'b0;
                    end else if (last_byte) begin
                        valid_r <= 1'b1;
                    end else begin
                        k_r <= k_r + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: memory addresses are held through the wait state so the RAM sees a stable address
    always_comb begin
        s_address   = '0;
        s_data      = '0;
        s_wren      = 1'b0;
        rom_address = '0;
        d_address   = '0;
        d_data      = '0;
        d_wren      = 1'b0;
        finish      = 1'b0;
        busy        = (state != IDLE);
        case (state)
            RD_I:    s_address = i_r + 8'd1;
            WT_I:    s_address = i_r;
            RD_J,
            WT_J:    s_address = j_r;
            WR_I: begin
                s_address = i_r;
                s_data    = sj_r;
                s_wren    = 1'b1;
            end
            WR_J: begin
                s_address = j_r;
                s_data    = si_r;
                s_wren    = 1'b1;
            end
            RD_F,
            WT_F: begin
                s_address   = si_r + sj_r;
                rom_address = k_r;
            end
            WR_O: begin
                d_address = k_r;
                d_data    = plain;
                d_wren    = 1'b1;
            end
            DONE:    finish = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rc4_prga_fsm.sv
// tb/tb_rc4_prga_fsm.sv - directed vector bench for rc4_prga_fsm with three message lengths

module tb_rc4_prga_fsm;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic check_en = 1'b0;
    logic start [3];
    logic load  [3];

    logic       finish [3];
    logic       busy   [3];
    logic       valid  [3];
    logic       s_wren [3];
    logic       d_wren [3];
    logic [7:0] s_address [3];
    logic [7:0] s_data    [3];
    logic [7:0] s_q       [3];
    logic [7:0] rom_q     [3];
    logic [7:0] d_data    [3];
    logic [7:0] rom_addr  [3];
    logic [7:0] d_addr    [3];

    logic [4:0] rom_a0, d_a0;
    logic [2:0] rom_a1, d_a1;
    logic [3:0] rom_a2, d_a2;

    assign rom_addr[0] = {3'b0, rom_a0};
    assign rom_addr[1] = {5'b0, rom_a1};
    assign rom_addr[2] = {4'b0, rom_a2};
    assign d_addr[0]   = {3'b0, d_a0};
    assign d_addr[1]   = {5'b0, d_a1};
    assign d_addr[2]   = {4'b0, d_a2};

    logic [7:0] s_img   [3][256];
    logic [7:0] rom_img [3][32];
    logic [7:0] exp_pt  [3][32];
    logic [7:0] s_mem   [3][256];
    logic [7:0] rom_mem [3][32];
    logic [7:0] d_mem   [3][32];
    logic [7:0] s_ar    [3];
    logic [7:0] r_ar    [3];
    int         wr_cnt  [3];

    int n_pass = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    rc4_prga_fsm #(.MSG_LEN(32)) u_dut32 (
        .clock(clock), .reset_n(reset_n), .start(start[0]), .check_en(check_en),
        .finish(finish[0]), .busy(busy[0]), .valid(valid[0]),
        .s_address(s_address[0]), .s_data(s_data[0]), .s_wren(s_wren[0]), .s_q(s_q[0]),
        .rom_address(rom_a0), .rom_q(rom_q[0]),
        .d_address(d_a0), .d_data(d_data[0]), .d_wren(d_wren[0])
    );

    rc4_prga_fsm #(.MSG_LEN(5)) u_dut5 (
        .clock(clock), .reset_n(reset_n), .start(start[1]), .check_en(check_en),
        .finish(finish[1]), .busy(busy[1]), .valid(valid[1]),
        .s_address(s_address[1]), .s_data(s_data[1]), .s_wren(s_wren[1]), .s_q(s_q[1]),
        .rom_address(rom_a1), .rom_q(rom_q[1]),
        .d_address(d_a1), .d_data(d_data[1]), .d_wren(d_wren[1])
    );

    rc4_prga_fsm #(.MSG_LEN(9)) u_dut9 (
        .clock(clock), .reset_n(reset_n), .start(start[2]), .check_en(check_en),
        .finish(finish[2]), .busy(busy[2]), .valid(valid[2]),
        .s_address(s_address[2]), .s_data(s_data[2]), .s_wren(s_wren[2]), .s_q(s_q[2]),
        .rom_address(rom_a2), .rom_q(rom_q[2]),
        .d_address(d_a2), .d_data(d_data[2]), .d_wren(d_wren[2])
    );

    // Memory models: registered address plus registered output (two-edge read), write-on-edge
    always @(posedge clock) begin
        for (int m = 0; m < 3; m++) begin
            if (load[m]) begin
                for (int a = 0; a < 256; a++) s_mem[m][a] <= s_img[m][a];
                for (int a = 0; a < 32; a++) begin
                    rom_mem[m][a] <= rom_img[m][a];
                    d_mem[m][a]   <= 8'h00;
                end
                wr_cnt[m] <= 0;
            end else begin
                if (s_wren[m]) s_mem[m][s_address[m]] <= s_data[m];
                if (d_wren[m]) begin
                    d_mem[m][d_addr[m][4:0]] <= d_data[m];
                    wr_cnt[m] <= wr_cnt[m] + 1;
                end
            end
            s_ar[m]  <= s_address[m];
            s_q[m]   <= s_mem[m][s_ar[m]];
            r_ar[m]  <= rom_addr[m];
            rom_q[m] <= rom_mem[m][r_ar[m][4:0]];
        end
    end

    typedef struct {
        int inst;
        bit chk;
        int edges;
        int writes;
        bit vld;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic ksa(input int m, input string key);
        int j;
        logic [7:0] t;
        for (int i = 0; i < 256; i++) s_img[m][i] = 8'(i);
        j = 0;
        for (int i = 0; i < 256; i++) begin
            j = (j + int'(s_img[m][i]) + int'(key[i % key.len()])) % 256;
            t = s_img[m][i];
            s_img[m][i] = s_img[m][j];
            s_img[m][j] = t;
        end
    endtask

    // Reference S after n keystream bytes, compared against the DUT's S RAM
    task automatic s_mismatches(input int m, input int n, output int bad);
        logic [7:0] rs [256];
        logic [7:0] t;
        int i, j;
        for (int a = 0; a < 256; a++) rs[a] = s_img[m][a];
        i = 0;
        j = 0;
        for (int b = 0; b < n; b++) begin
            i = (i + 1) % 256;
            j = (j + int'(rs[i])) % 256;
            t = rs[i];
            rs[i] = rs[j];
            rs[j] = t;
        end
        bad = 0;
        for (int a = 0; a < 256; a++) if (s_mem[m][a] !== rs[a]) bad++;
    endtask

    task automatic prep(input int m);
        @(negedge clock);
        load[m] = 1'b1;
        @(negedge clock);
        load[m] = 1'b0;
    endtask

    task automatic wait_finish(input int m, output int edges);
        edges = 0;
        while (edges < 5000) begin
            @(posedge clock);
            edges++;
            #1;
            if (finish[m]) break;
        end
    endtask

    task automatic run(input int m, input bit chk, output int edges);
        prep(m);
        check_en = chk;
        start[m] = 1'b1;
        @(posedge clock);
        #1;
        start[m] = 1'b0;
        wait_finish(m, edges);
    endtask

    initial begin
        int edges;
        int bad;
        string pw;
        string pk;

        for (int m = 0; m < 3; m++) begin
            start[m] = 1'b0;
            load[m]  = 1'b0;
            for (int a = 0; a < 32; a++) begin
                rom_img[m][a] = 8'h00;
                exp_pt[m][a]  = 8'h00;
            end
        end
        for (int a = 0; a < 256; a++) s_img[0][a] = 8'h12;
        for (int a = 0; a < 32; a++) begin
            rom_img[0][a] = 8'hAF;
            exp_pt[0][a]  = 8'hBD;
        end
        ksa(1, "Wiki");
        ksa(2, "Key");
        {rom_img[1][0], rom_img[1][1], rom_img[1][2], rom_img[1][3], rom_img[1][4]} =
            40'h10_21_BF_04_20;
        {rom_img[2][0], rom_img[2][1], rom_img[2][2], rom_img[2][3], rom_img[2][4],
         rom_img[2][5], rom_img[2][6], rom_img[2][7], rom_img[2][8]} =
            72'hBB_F3_16_E8_D9_40_AF_0A_D3;
        pw = "pedia";
        pk = "Plaintext";
        for (int b = 0; b < 5; b++) exp_pt[1][b] = pw[b];
        for (int b = 0; b < 9; b++) exp_pt[2][b] = pk[b];

        vt[0] = '{0, 1'b0, 353, 32, 1'b1};
        vt[1] = '{0, 1'b1,  12,  1, 1'b0};
        vt[2] = '{1, 1'b1,  56,  5, 1'b1};
        vt[3] = '{2, 1'b0, 100,  9, 1'b1};
        vt[4] = '{1, 1'b0,  56,  5, 1'b1};
        vt[5] = '{2, 1'b1,  12,  1, 1'b0};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy",   int'(busy[0]), 0);
        check("rst_finish", int'(finish[0]), 0);
        check("rst_valid",  int'(valid[0]), 0);
        check("rst_wren",   int'({s_wren[0], d_wren[0]}), 0);
        check("rst_addr",   int'({s_address[0], s_data[0], rom_addr[0], d_addr[0], d_data[0]}), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Vector table
        for (int v = 0; v < 6; v++) begin
            int m;
            m = vt[v].inst;
            run(m, vt[v].chk, edges);
            check($sformatf("v%0d_edges", v), edges, vt[v].edges);
            check($sformatf("v%0d_valid", v), int'(valid[m]), int'(vt[v].vld));
            @(negedge clock);
            check($sformatf("v%0d_writes", v), wr_cnt[m], vt[v].writes);
            bad = 0;
            for (int b = 0; b < 32; b++) begin
                if (d_mem[m][b] !== ((b < vt[v].writes) ? exp_pt[m][b] : 8'h00)) bad++;
            end
            check($sformatf("v%0d_data", v), bad, 0);
            @(posedge clock);
            #1;
            check($sformatf("v%0d_idle", v), int'({busy[m], finish[m]}), 0);
            check($sformatf("v%0d_vhold", v), int'(valid[m]), int'(vt[v].vld));
            if (m == 2 && !vt[v].chk) begin
                s_mismatches(2, 9, bad);
                check($sformatf("v%0d_final_s", v), bad, 0);
            end
        end

        // Reset asserted during byte 3 (state WR_I of that byte)
        prep(0);
        check_en = 1'b0;
        start[0] = 1'b1;
        @(posedge clock);
        #1;
        start[0] = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        check("mid_wren_before", int'(s_wren[0]), 1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mid_wren_after", int'({s_wren[0], d_wren[0]}), 0);
        check("mid_busy", int'(busy[0]), 0);
        check("mid_saddr", int'(s_address[0]), 0);
        repeat (2) @(posedge clock);
        #1;
        check("mid_writes", wr_cnt[0], 3);
        @(negedge clock);
        reset_n = 1'b1;
        run(0, 1'b0, edges);
        check("post_rst_edges", edges, 353);
        @(negedge clock);
        check("post_rst_writes", wr_cnt[0], 32);

        // Start held high across the whole run and through DONE
        prep(0);
        check_en = 1'b0;
        start[0] = 1'b1;
        @(posedge clock);
        wait_finish(0, edges);
        check("held_edges1", edges, 353);
        @(posedge clock);
        #1;
        check("held_idle", int'(busy[0]), 0);
        @(posedge clock);
        #1;
        start[0] = 1'b0;
        check("held_restart", int'(busy[0]), 1);
        wait_finish(0, edges);
        check("held_edges2", edges, 353);
        repeat (30) @(posedge clock);
        #1;
        check("held_no_third", int'(busy[0]), 0);
        check("held_writes", wr_cnt[0], 64);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
